// File: rtl/serializador.sv
// Byte-to-bit serializer: one holding register feeds an 8-bit MSB-first shift
// register under a valid/ready handshake on both the parallel and serial sides.
module serializador (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       write_in,
  output logic       ready_out,
  input  logic       ready_in,
  output logic       data_out,
  output logic       write_out,
  output logic       done_out,
  output logic       status_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [7:0] hold_r;
  logic       hold_valid_r;
  logic [7:0] shift_r;
  logic [2:0] count_r;
  logic       load_s;
  logic       consume_s;
  logic       accept_s;

  // A byte is only taken while the holding register is empty.
  assign accept_s = write_in & ~hold_valid_r;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; load_s moves hold into shift, consume_s advances one bit.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    consume_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (hold_valid_r) begin
          load_s  = 1'b1;
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (ready_in) begin
          consume_s = 1'b1;
          if (count_r == 3'd7) begin
            state_s = DONE;
          end else begin
            state_s = SEND;
          end
        end else begin
          state_s = SEND;
        end
      end
      DONE: begin
        if (hold_valid_r) begin
          load_s  = 1'b1;
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Holding register; load and accept are exclusive since load needs hold_valid=1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_r       <= 8'h00;
      hold_valid_r <= 1'b0;
    end else if (load_s) begin
      hold_valid_r <= 1'b0;
    end else if (accept_s) begin
      hold_r       <= data_in;
      hold_valid_r <= 1'b1;
    end
  end

  // Shift register and bit counter; the counter wraps to 0 after bit 7.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_r <= 8'h00;
      count_r <= 3'd0;
    end else if (load_s) begin
      shift_r <= hold_r;
      count_r <= 3'd0;
    end else if (consume_s) begin
      shift_r <= {shift_r[6:0], 1'b0};
      count_r <= count_r + 3'd1;
    end
  end

  assign ready_out  = ~hold_valid_r;
  assign write_out  = (state_r == SEND);
  assign data_out   = (state_r == SEND) & shift_r[7];
  assign done_out   = (state_r == DONE);
  assign status_out = (state_r != IDLE);

endmodule
